// File: rtl/intr_pkg_6801.sv
// ============================================================================
// intr_pkg_6801 : interrupt sequencer command type and decode helper
// Revision 1.0
// ============================================================================
`default_nettype none

package intr_pkg_6801;

  typedef enum logic [2:0] {
    cmd_latch     = 3'd0,
    cmd_ack_nmi   = 3'd1,
    cmd_ack_irq   = 3'd2,
    cmd_clear_all = 3'd3,
    cmd_arm_nmi   = 3'd4
  } intr_cmd_type;

  // Any encoding outside the defined set behaves as a no-op latch.
  function automatic intr_cmd_type decode_cmd(input logic [2:0] raw);
    case (raw)
      3'd1:    decode_cmd = cmd_ack_nmi;
      3'd2:    decode_cmd = cmd_ack_irq;
      3'd3:    decode_cmd = cmd_clear_all;
      3'd4:    decode_cmd = cmd_arm_nmi;
      default: decode_cmd = cmd_latch;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/intr_sync_6801.sv
// ============================================================================
// intr_sync_6801 : STAGES-deep synchroniser, resets to 1 (inactive-high line)
// Revision 1.0
// ============================================================================
`default_nettype none

module intr_sync_6801 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = STAGES'({sync_q, d});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/intr_latch_6801.sv
// ============================================================================
// intr_latch_6801 : NMI + N_IRQ interrupt request latch with fixed priority.
// Optional INTR_NMI_ARM_EN adds an NMI arm flop set by cmd_arm_nmi.
// Revision 1.0
// ============================================================================
`default_nettype none

module intr_latch_6801
  import intr_pkg_6801::*;
#(
  parameter int               N_IRQ       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] EDGE_MASK   = '0
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         hold,
  input  logic                                         nmi_n,
  input  logic [N_IRQ-1:0]                             irq_n,
  input  logic                                         i_mask,
  input  intr_cmd_type                                 int_cmd,
  output logic                                         nmi_req,
  output logic                                         irq_req,
  output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] irq_id,
  output logic [N_IRQ-1:0]                             irq_pend
);

  localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  function automatic logic [IDW-1:0] prio_enc(input logic [N_IRQ-1:0] p);
    prio_enc = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (p[i]) prio_enc = IDW'(i);
    end
  endfunction

  logic             nmi_s;
  logic [N_IRQ-1:0] irq_s;

  intr_sync_6801 #(.STAGES(SYNC_STAGES)) u_sync_nmi (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (nmi_n),
    .q       (nmi_s)
  );

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_irq_sync
      intr_sync_6801 #(.STAGES(SYNC_STAGES)) u_sync_irq (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (irq_n[gi]),
        .q       (irq_s[gi])
      );
    end
  endgenerate

  logic             nmi_hist_q, nmi_hist_d;
  logic             nmi_pend_q, nmi_pend_d;
  logic [N_IRQ-1:0] irq_hist_q, irq_hist_d;
  logic [N_IRQ-1:0] irq_pend_q, irq_pend_d;
  logic [IDW-1:0]   irq_id_w;
  logic             nmi_armed;
  intr_cmd_type     cmd;
  logic             do_ack_nmi, do_ack_irq, do_clear_all;
  logic             nmi_fall;
  logic [N_IRQ-1:0] irq_fall;

  assign irq_id_w = prio_enc(irq_pend_q);

  // Commands are only honoured outside hold.
  always_comb begin
    cmd          = decode_cmd(int_cmd);
    do_ack_nmi   = !hold && (cmd == cmd_ack_nmi);
    do_ack_irq   = !hold && (cmd == cmd_ack_irq);
    do_clear_all = !hold && (cmd == cmd_clear_all);
  end

`ifdef INTR_NMI_ARM_EN
  logic nmi_armed_q, nmi_armed_d;

  always_comb begin
    nmi_armed_d = nmi_armed_q;
    if (!hold && (cmd == cmd_arm_nmi)) nmi_armed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_armed_q <= 1'b0;
    end else begin
      nmi_armed_q <= nmi_armed_d;
    end
  end

  assign nmi_armed = nmi_armed_q;
`else
  assign nmi_armed = 1'b1;
`endif

  always_comb begin
    nmi_fall = nmi_hist_q & ~nmi_s & nmi_armed;
    irq_fall = irq_hist_q & ~irq_s & EDGE_MASK;

    nmi_hist_d = hold ? nmi_hist_q : nmi_s;
    irq_hist_d = hold ? irq_hist_q : irq_s;

    // Clear first, then set, so a fresh edge survives a same-cycle ack.
    nmi_pend_d = nmi_pend_q;
    if (!hold) begin
      if (do_ack_nmi || do_clear_all) nmi_pend_d = 1'b0;
      if (nmi_fall)                   nmi_pend_d = 1'b1;
    end

    irq_pend_d = irq_pend_q;
    if (!hold) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (EDGE_MASK[i]) begin
          if (do_clear_all || (do_ack_irq && (irq_id_w == IDW'(i)))) irq_pend_d[i] = 1'b0;
          if (irq_fall[i]) irq_pend_d[i] = 1'b1;
        end else begin
          irq_pend_d[i] = ~irq_s[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_hist_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      irq_hist_q <= '1;
      irq_pend_q <= '0;
    end else begin
      nmi_hist_q <= nmi_hist_d;
      nmi_pend_q <= nmi_pend_d;
      irq_hist_q <= irq_hist_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign nmi_req  = nmi_pend_q;
  assign irq_pend = irq_pend_q;
  assign irq_id   = irq_id_w;
  assign irq_req  = (|irq_pend_q) & ~i_mask;

endmodule

`default_nettype wire

// File: tb/tb_intr_latch_6801.sv
// ============================================================================
// tb_intr_latch_6801 : directed self-checking bench, channels 1 and 3 edge mode
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_intr_latch_6801;
  import intr_pkg_6801::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         hold;
  logic         nmi_n;
  logic [3:0]   irq_n;
  logic         i_mask;
  intr_cmd_type int_cmd;
  logic         nmi_req;
  logic         irq_req;
  logic [1:0]   irq_id;
  logic [3:0]   irq_pend;

  int n_vec = 0;
  int n_err = 0;

  intr_latch_6801 #(
    .N_IRQ       (4),
    .SYNC_STAGES (2),
    .EDGE_MASK   (4'b1010)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hold     (hold),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .i_mask   (i_mask),
    .int_cmd  (int_cmd),
    .nmi_req  (nmi_req),
    .irq_req  (irq_req),
    .irq_id   (irq_id),
    .irq_pend (irq_pend)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic nmi_pulse();
    nmi_n = 1'b0;
    tick(1);
    nmi_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hold = 1'b0; nmi_n = 1'b1; irq_n = 4'b1111;
    i_mask = 1'b0; int_cmd = cmd_latch;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    n_vec++; if (nmi_req !== 1'b0) begin n_err++; $display("FAIL reset_nmi_req got %b exp 0", nmi_req); end
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL reset_irq_req got %b exp 0", irq_req); end
    n_vec++; if (irq_id !== 2'd0) begin n_err++; $display("FAIL reset_irq_id got %0d exp 0", irq_id); end
    n_vec++; if (irq_pend !== 4'b0000) begin n_err++; $display("FAIL reset_irq_pend got %b exp 0000", irq_pend); end
  endtask

  task automatic test_level();
    irq_n[2] = 1'b0;
    tick(2);
    n_vec++; if (irq_pend !== 4'b0000) begin n_err++; $display("FAIL level_early got %b exp 0000", irq_pend); end
    tick(1);
    n_vec++; if (irq_pend !== 4'b0100) begin n_err++; $display("FAIL level_pend got %b exp 0100", irq_pend); end
    n_vec++; if (irq_req !== 1'b1) begin n_err++; $display("FAIL level_req got %b exp 1", irq_req); end
    n_vec++; if (irq_id !== 2'd2) begin n_err++; $display("FAIL level_id got %0d exp 2", irq_id); end
    i_mask = 1'b1;
    #1;
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL masked_req got %b exp 0", irq_req); end
    n_vec++; if (irq_pend !== 4'b0100) begin n_err++; $display("FAIL masked_pend got %b exp 0100", irq_pend); end
    tick(1);
    int_cmd = cmd_ack_irq;
    tick(1);
    int_cmd = cmd_clear_all;
    tick(1);
    int_cmd = cmd_latch;
    n_vec++; if (irq_pend !== 4'b0100) begin n_err++; $display("FAIL level_ack_ignored got %b exp 0100", irq_pend); end
    irq_n[2] = 1'b1;
    tick(3);
    n_vec++; if (irq_pend !== 4'b0000) begin n_err++; $display("FAIL level_release got %b exp 0000", irq_pend); end
    i_mask = 1'b0;
  endtask

  task automatic test_edge_priority();
    irq_n[1] = 1'b0; irq_n[3] = 1'b0;
    tick(3);
    n_vec++; if (irq_pend !== 4'b1010) begin n_err++; $display("FAIL edge_pend got %b exp 1010", irq_pend); end
    n_vec++; if (irq_id !== 2'd1) begin n_err++; $display("FAIL edge_id_first got %0d exp 1", irq_id); end
    int_cmd = cmd_ack_irq;
    tick(1);
    int_cmd = cmd_latch;
    n_vec++; if (irq_id !== 2'd3) begin n_err++; $display("FAIL edge_id_second got %0d exp 3", irq_id); end
    n_vec++; if (irq_pend !== 4'b1000) begin n_err++; $display("FAIL edge_pend_after_ack got %b exp 1000", irq_pend); end
    tick(2);
    n_vec++; if (irq_pend !== 4'b1000) begin n_err++; $display("FAIL edge_no_rearm got %b exp 1000", irq_pend); end
    int_cmd = cmd_ack_irq;
    tick(1);
    int_cmd = cmd_latch;
    n_vec++; if (irq_pend !== 4'b0000) begin n_err++; $display("FAIL edge_all_acked got %b exp 0000", irq_pend); end
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL edge_req_off got %b exp 0", irq_req); end
    irq_n[1] = 1'b1; irq_n[3] = 1'b1;
    tick(3);
  endtask

  task automatic test_set_wins();
    irq_n[1] = 1'b0;
    tick(3);
    irq_n[1] = 1'b1;
    tick(3);
    n_vec++; if (irq_pend !== 4'b0010) begin n_err++; $display("FAIL setwins_pre got %b exp 0010", irq_pend); end
    irq_n[1] = 1'b0;
    tick(2);
    int_cmd = cmd_ack_irq;
    tick(1);
    int_cmd = cmd_latch;
    n_vec++; if (irq_pend !== 4'b0010) begin n_err++; $display("FAIL setwins_keep got %b exp 0010", irq_pend); end
    int_cmd = cmd_ack_irq;
    tick(1);
    int_cmd = cmd_latch;
    n_vec++; if (irq_pend !== 4'b0000) begin n_err++; $display("FAIL setwins_clear got %b exp 0000", irq_pend); end
    irq_n[1] = 1'b1;
    tick(3);
  endtask

  task automatic test_nmi();
`ifdef INTR_NMI_ARM_EN
    nmi_pulse();
    tick(2);
    n_vec++; if (nmi_req !== 1'b0) begin n_err++; $display("FAIL nmi_disarmed got %b exp 0", nmi_req); end
    int_cmd = cmd_arm_nmi;
    tick(1);
    int_cmd = cmd_latch;
`endif
    nmi_n = 1'b0;
    tick(1);
    nmi_n = 1'b1;
    tick(1);
    n_vec++; if (nmi_req !== 1'b0) begin n_err++; $display("FAIL nmi_early got %b exp 0", nmi_req); end
    tick(1);
    n_vec++; if (nmi_req !== 1'b1) begin n_err++; $display("FAIL nmi_set got %b exp 1", nmi_req); end
    tick(4);
    n_vec++; if (nmi_req !== 1'b1) begin n_err++; $display("FAIL nmi_sticky got %b exp 1", nmi_req); end
    hold = 1'b1;
    int_cmd = cmd_ack_nmi;
    tick(2);
    n_vec++; if (nmi_req !== 1'b1) begin n_err++; $display("FAIL nmi_hold_ack got %b exp 1", nmi_req); end
    hold = 1'b0;
    tick(1);
    int_cmd = cmd_latch;
    n_vec++; if (nmi_req !== 1'b0) begin n_err++; $display("FAIL nmi_ack got %b exp 0", nmi_req); end
  endtask

  task automatic test_clear_all();
    irq_n[3] = 1'b0;
    nmi_pulse();
    n_vec++; if (nmi_req !== 1'b1 || irq_pend !== 4'b1000) begin n_err++; $display("FAIL clr_pre got nmi=%b pend=%b exp nmi=1 pend=1000", nmi_req, irq_pend); end
    int_cmd = intr_cmd_type'(3'd6);
    tick(1);
    n_vec++; if (nmi_req !== 1'b1 || irq_pend !== 4'b1000) begin n_err++; $display("FAIL undefined_cmd got nmi=%b pend=%b exp nmi=1 pend=1000", nmi_req, irq_pend); end
`ifndef INTR_NMI_ARM_EN
    int_cmd = cmd_arm_nmi;
    tick(1);
    n_vec++; if (nmi_req !== 1'b1 || irq_pend !== 4'b1000) begin n_err++; $display("FAIL arm_as_latch got nmi=%b pend=%b exp nmi=1 pend=1000", nmi_req, irq_pend); end
`endif
    int_cmd = cmd_clear_all;
    tick(1);
    int_cmd = cmd_latch;
    n_vec++; if (nmi_req !== 1'b0 || irq_pend !== 4'b0000) begin n_err++; $display("FAIL clr_all got nmi=%b pend=%b exp nmi=0 pend=0000", nmi_req, irq_pend); end
    irq_n[3] = 1'b1;
    tick(3);
`ifdef INTR_NMI_ARM_EN
    nmi_pulse();
    n_vec++; if (nmi_req !== 1'b1) begin n_err++; $display("FAIL clr_keeps_arm got %b exp 1", nmi_req); end
    int_cmd = cmd_ack_nmi;
    tick(1);
    int_cmd = cmd_latch;
`endif
  endtask

  task automatic test_hold_edge();
    hold = 1'b1;
    irq_n[1] = 1'b0;
    tick(4);
    n_vec++; if (irq_pend !== 4'b0000) begin n_err++; $display("FAIL hold_frozen got %b exp 0000", irq_pend); end
    hold = 1'b0;
    tick(1);
    n_vec++; if (irq_pend !== 4'b0010) begin n_err++; $display("FAIL hold_release_edge got %b exp 0010", irq_pend); end
    int_cmd = cmd_clear_all;
    tick(1);
    int_cmd = cmd_latch;
    irq_n[1] = 1'b1;
    tick(3);
  endtask

  task automatic test_reset_mid();
    irq_n[0] = 1'b0;
    nmi_pulse();
    n_vec++; if (nmi_req !== 1'b1 || irq_pend !== 4'b0001) begin n_err++; $display("FAIL rstmid_pre got nmi=%b pend=%b exp nmi=1 pend=0001", nmi_req, irq_pend); end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (nmi_req !== 1'b0 || irq_pend !== 4'b0000 || irq_req !== 1'b0) begin n_err++; $display("FAIL rstmid_async got nmi=%b pend=%b req=%b exp 0 0000 0", nmi_req, irq_pend, irq_req); end
    irq_n[0] = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(3);
`ifdef INTR_NMI_ARM_EN
    nmi_pulse();
    tick(1);
    n_vec++; if (nmi_req !== 1'b0) begin n_err++; $display("FAIL rstmid_disarmed got %b exp 0", nmi_req); end
`endif
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_priority();
    test_set_wins();
    test_nmi();
    test_clear_all();
    test_hold_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
